plab4_net_router_output_ctrl_tp: RTL and testbench
==================================================

# plab4_net_router_output_ctrl_tp

Per-output-port control for the timing-protected router. It sits directly downstream of the three input controls: it collects their `reqs` bits for this output, arbitrates round-robin, and returns `grants`. It also owns the time-division slot counter that drives the `domain0`/`domain1` enables those input controls consume. Traffic from each security domain is therefore confined to its own time slot. Each slot ends in guard cycles so an in-flight transfer cannot spill into the other domain's slot.

## Interface
Parameters:
- `p_num_reqs`, 3: number of requesting input ports; fixed at 3 for the ring router.
- `p_slot_len`, 8: cycles per domain slot; legal values are ≥ 2.
- `p_guard_len`, 1: trailing cycles of each slot in which no grant may issue; must satisfy 0 ≤ value < `p_slot_len`.

Ports:
- `clk`  in  1  the single clock.
- `reset`  in  1  asynchronous, active-high.
- `reqs`  in  3  request vector; bit i comes from input control i.
- `out_rdy`  in  1  downstream output channel can accept.
- `grants`  out  3  one-hot or zero; returned to the input controls.
- `out_val`  out  1  a transfer fires this cycle.
- `sel`  out  2  binary index of the granted input, used as the crossbar mux select; 0 when no grant.
- `domain0`  out  1  domain-0 slot active and not in guard.
- `domain1`  out  1  domain-1 slot active and not in guard.
- `cur_domain`  out  1  raw slot owner, including guard cycles; for debug and verification.

## Operation
- Slot counter `cnt` has width ceil(log2(`p_slot_len`)) and increments every cycle.
  - At `cnt == p_slot_len-1` it wraps to 0 and `cur_domain` toggles.
- `guard` = (`cnt >= p_slot_len - p_guard_len`).
- `domain0` = !`cur_domain` && !`guard`; `domain1` = `cur_domain` && !`guard`. The two are never high together.
- Arbitration uses a one-hot priority register `prio`.
  - The grant goes to the first requester at or after `prio`, scanning upward with wrap.
  - Grants are issued only when `out_rdy` && !`guard` && !`reset`; otherwise `grants` = 0.
- `out_val` = |`grants`. `sel` is the encoded `grants`.
- On a firing cycle (`out_val`), `prio` moves to the bit one above the winner (rotate left of `grants`). Otherwise `prio` holds.
- Domain filtering is not done here. The input controls gate `reqs` with `domain0`/`domain1`. This block only guarantees that no grant issues during guard cycles and that the domains' slots alternate.

## Timing
- Reset values, applied asynchronously and held while `reset` is high:
  - `cnt` = 0, `cur_domain` = 0, `prio` = 3'b001.
  - `grants` = 0, `out_val` = 0, `sel` = 0, `domain0` = 0, `domain1` = 0.
- First cycle after reset deassertion: `domain0` = 1 (if `p_slot_len - p_guard_len` ≥ 1, which always holds).
- `grants`, `out_val` and `sel` are combinational from `reqs`, `out_rdy`, `prio` and `guard`, with zero-cycle latency. The input controls' `in_rdy` follows in the same cycle.
- `domain0`/`domain1` are functions of registered state only, so they carry no combinational path from `reqs`.
- Slot boundary example (`p_slot_len`=8, `p_guard_len`=1):
  - `cnt` 0–6: the owning domain is active.
  - `cnt` 7: guard; both enables are 0 and no grant issues.
  - Next cycle: `cnt` = 0 and the other domain becomes active.
- With `p_guard_len` = 0, enables switch directly and grants can issue on every cycle.
- A request that arrives on a guard cycle is not granted. It wins only after the next slot starts, if its domain owns that slot.
- If several inputs request at once, exactly one is granted. `prio` never changes on a cycle with no grant, including `out_rdy` low.
- Reset asserted mid-transfer: all outputs drop immediately and the counter restarts at domain 0.

## Structure
- `p_slot_len`/`p_guard_len` defaults and domain encodings (`DOMAIN0`=0, `DOMAIN1`=1) go in the shared net `define` include, which the input controls also use.
- One sub-module: `plab4_net_tdm_slot_counter`. It holds `cnt`, `cur_domain` and `guard` and produces the two enables. The arbiter and priority register stay in the top module.
- Elaboration check: flag an error if `p_guard_len >= p_slot_len` or `p_slot_len < 2`.

## Test plan
Defaults for all scenarios: `p_slot_len`=8, `p_guard_len`=1.
- Reset then idle for 16 cycles, `reqs`=0:
  - `domain0`=1 for cycles 0–6 and 0 on cycle 7.
  - `domain1`=1 for cycles 8–14 and 0 on cycle 15.
  - `grants`=0 throughout.
- Single requester, `reqs`=3'b010, `out_rdy`=1, `cnt`=2 → `grants`=3'b010, `sel`=1, `out_val`=1; next-cycle `prio`=3'b100.
- All requesting (`reqs`=3'b111), `out_rdy`=1, 3 non-guard cycles from reset → grants 001, 010, 100 in that order, then 001 again.
- Guard cycle (`cnt`=7), `reqs`=3'b001, `out_rdy`=1 → `grants`=0 and `out_val`=0. Next cycle (`domain1` slot, `cnt`=0), still `reqs`=3'b001 → `grants`=3'b001.
- Backpressure: `reqs`=3'b101, `out_rdy`=0 for 3 cycles → `grants`=0 and `prio` stays 3'b001. When `out_rdy` rises → `grants`=3'b001.
- Assert `reset` at `cnt`=5 with a grant active → `grants`, `domain0` and `domain1` all drop to 0 immediately. After deassertion, `cnt` restarts at 0 with `domain0`=1 and `prio`=3'b001.

Source files
------------

// File: rtl/plab4_net_router_output_ctrl_tp_pkg.sv
// Shared types, defaults and helpers for the
// timing-protected router output control.
package plab4_net_router_output_ctrl_tp_pkg;

  localparam int NUM_REQS  = 3;
  localparam int SLOT_LEN  = 8;
  localparam int GUARD_LEN = 1;

  typedef enum logic {
    DOMAIN0 = 1'b0,
    DOMAIN1 = 1'b1
  } domain_e;

  typedef logic [NUM_REQS-1:0] req_vec_t;

  function automatic logic [1:0] enc3(req_vec_t v);
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      v[1]:    idx = 2'd1;
      v[2]:    idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // First requester at or after the one-hot prio, with wrap.
  function automatic req_vec_t rr_pick(
    req_vec_t r,
    req_vec_t p
  );
    req_vec_t g;
    g = '0;
    unique case (1'b1)
      p[1]: g = r[1] ? 3'b010 :
                r[2] ? 3'b100 :
                r[0] ? 3'b001 : 3'b000;
      p[2]: g = r[2] ? 3'b100 :
                r[0] ? 3'b001 :
                r[1] ? 3'b010 : 3'b000;
      default:
            g = r[0] ? 3'b001 :
                r[1] ? 3'b010 :
                r[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/plab4_net_router_output_ctrl_tp_if.sv
// Request/grant bundle between the input controls
// and one output control.
interface plab4_net_router_output_ctrl_tp_if;
  import plab4_net_router_output_ctrl_tp_pkg::*;

  req_vec_t   reqs;
  logic       out_rdy;
  req_vec_t   grants;
  logic       out_val;
  logic [1:0] sel;

  modport master (
    output reqs,
    output out_rdy,
    input  grants,
    input  out_val,
    input  sel
  );

  modport slave (
    input  reqs,
    input  out_rdy,
    output grants,
    output out_val,
    output sel
  );

endinterface

// File: rtl/plab4_net_router_output_ctrl_tp_slot_counter.sv
// Time-division slot counter: alternating domain
// slots, each closed by trailing guard cycles.
module plab4_net_tdm_slot_counter
  import plab4_net_router_output_ctrl_tp_pkg::*;
#(
  parameter int p_slot_len  = SLOT_LEN,
  parameter int p_guard_len = GUARD_LEN
) (
  input  logic    clk,
  input  logic    reset,
  output domain_e cur_domain,
  output logic    guard,
  output logic    domain0,
  output logic    domain1
);

  localparam int CW = $clog2(p_slot_len);
  localparam logic [CW-1:0] LAST =
    CW'(p_slot_len - 1);
  localparam logic [31:0] GSTART =
    32'(p_slot_len - p_guard_len);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  domain_e       dom_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      cur_domain <= DOMAIN0;
    end else begin
      cnt        <= cnt_next;
      cur_domain <= dom_next;
    end
  end

  always_comb begin
    cnt_next = cnt + 1'b1;
    dom_next = cur_domain;
    if (cnt == LAST) begin
      cnt_next = '0;
      dom_next = (cur_domain == DOMAIN0) ?
                 DOMAIN1 : DOMAIN0;
    end
  end

  // Widened compare keeps guard_len = 0 from aliasing.
  assign guard   = (32'(cnt) >= GSTART);
  assign domain0 = !reset && !guard &&
                   (cur_domain == DOMAIN0);
  assign domain1 = !reset && !guard &&
                   (cur_domain == DOMAIN1);

endmodule

// File: rtl/plab4_net_router_output_ctrl_tp.sv
// Output-port control: round-robin arbiter gated
// by the TDM slot counter's guard window.
module plab4_net_router_output_ctrl_tp
  import plab4_net_router_output_ctrl_tp_pkg::*;
#(
  parameter int p_num_reqs  = NUM_REQS,
  parameter int p_slot_len  = SLOT_LEN,
  parameter int p_guard_len = GUARD_LEN
) (
  input  logic clk,
  input  logic reset,
  plab4_net_router_output_ctrl_tp_if.slave port,
  output logic domain0,
  output logic domain1,
  output logic cur_domain
);

  if (p_slot_len < 2 ||
      p_guard_len < 0 ||
      p_guard_len >= p_slot_len ||
      p_num_reqs != NUM_REQS) begin : g_bad_cfg
    $error("illegal slot/guard/reqs params");
  end

  domain_e  dom;
  logic     guard;
  logic     fire_ok;
  req_vec_t prio;
  req_vec_t grants_c;

  plab4_net_tdm_slot_counter #(
    .p_slot_len  (p_slot_len),
    .p_guard_len (p_guard_len)
  ) slot_cnt (
    .clk        (clk),
    .reset      (reset),
    .cur_domain (dom),
    .guard      (guard),
    .domain0    (domain0),
    .domain1    (domain1)
  );

  assign cur_domain = dom;

  assign fire_ok  = port.out_rdy && !guard &&
                    !reset;
  assign grants_c = fire_ok ?
                    rr_pick(port.reqs, prio) : '0;

  assign port.grants  = grants_c;
  assign port.out_val = |grants_c;
  assign port.sel     = enc3(grants_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      prio <= 3'b001;
    else if (|grants_c)
      prio <= {grants_c[1:0], grants_c[2]};
  end

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_tp.sv
// Scoreboard bench: slot/arbiter reference model
// vs. the output control under random traffic.
module tb_plab4_net_router_output_ctrl_tp;

  localparam int L = 8;
  localparam int G = 1;

  logic clk;
  logic reset;
  logic domain0;
  logic domain1;
  logic cur_domain;

  plab4_net_router_output_ctrl_tp_if bus();

  plab4_net_router_output_ctrl_tp #(
    .p_num_reqs  (3),
    .p_slot_len  (L),
    .p_guard_len (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .port       (bus.slave),
    .domain0    (domain0),
    .domain1    (domain1),
    .cur_domain (cur_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];

  // model state: cycles since reset, rr pointer
  int t = 0;
  int ptr = 0;

  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.grants, bus.sel, bus.out_val,
             domain0, domain1, cur_domain};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b exp=%b",
                 $time, act, exp);
      end
    end
  end

  task automatic step(input logic r,
                      input logic [2:0] rq,
                      input logic rdy);
    logic [2:0] g;
    logic [1:0] s;
    int c;
    int dom;
    int idx;
    logic grd;
    reset       = r;
    bus.reqs    = rq;
    bus.out_rdy = rdy;
    g = 3'b000;
    s = 2'd0;
    if (r) begin
      t   = 0;
      ptr = 0;
      exp_q.push_back(9'b0);
    end else begin
      c   = t % L;
      dom = (t / L) % 2;
      grd = (c >= L - G);
      if (rdy && !grd) begin
        for (int k = 0; k < 3; k++) begin
          idx = (ptr + k) % 3;
          if (g == 3'b000 && rq[idx]) begin
            g = 3'b001 << idx;
            s = 2'(idx);
          end
        end
        if (g != 3'b000) ptr = (s + 1) % 3;
      end
      exp_q.push_back({g, s, |g,
                       (dom == 0) && !grd,
                       (dom == 1) && !grd,
                       1'(dom)});
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_prio(input logic [2:0] e,
                            input string nm);
    checks++;
    if (dut.prio !== e) begin
      errors++;
      $display("FAIL %s prio got=%b exp=%b",
               nm, dut.prio, e);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.reqs    = '0;
    bus.out_rdy = 1'b0;
    @(posedge clk);
    #1;
    step(1, 3'b000, 0);
    step(1, 3'b000, 0);
    check_prio(3'b001, "reset");
    for (int i = 0; i < 16; i++)
      step(0, 3'b000, 1);

    // single requester at cnt=2
    step(1, 3'b000, 0);
    step(0, 3'b000, 1);
    step(0, 3'b000, 1);
    step(0, 3'b010, 1);
    check_prio(3'b100, "single");

    // all requesting rotates 001,010,100,001
    step(1, 3'b000, 0);
    for (int i = 0; i < 4; i++)
      step(0, 3'b111, 1);
    check_prio(3'b010, "rotate");

    // guard cycle then domain1 slot
    step(1, 3'b000, 0);
    for (int i = 0; i < 7; i++)
      step(0, 3'b000, 1);
    step(0, 3'b001, 1);
    check_prio(3'b001, "guard");
    step(0, 3'b001, 1);
    check_prio(3'b010, "slot1");

    // backpressure
    step(1, 3'b000, 0);
    for (int i = 0; i < 3; i++)
      step(0, 3'b101, 0);
    check_prio(3'b001, "bp");
    step(0, 3'b101, 1);
    check_prio(3'b010, "bp_rel");

    // reset mid-transfer at cnt=5
    step(1, 3'b000, 0);
    for (int i = 0; i < 5; i++)
      step(0, 3'b000, 1);
    step(0, 3'b111, 1);
    step(1, 3'b111, 1);
    check_prio(3'b001, "midrst");
    step(0, 3'b111, 1);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
